// File: rtl/hilo_unit_if.sv
// Request/response bundle between the EX stage and the HI/LO unit.
interface hilo_unit_if;
  logic        ex_valid;
  logic [3:0]  alusignal;
  logic [31:0] alu_hi;
  logic [31:0] alu_lo;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        mfhi;
  logic        mflo;
  logic [31:0] rdata;
  logic        stall;
  logic        busy;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  modport master (
    output ex_valid, alusignal, alu_hi, alu_lo, mthi, mtlo, wdata, mfhi, mflo,
    input  rdata, stall, busy, hi_q, lo_q
  );

  modport slave (
    input  ex_valid, alusignal, alu_hi, alu_lo, mthi, mtlo, wdata, mfhi, mflo,
    output rdata, stall, busy, hi_q, lo_q
  );
endinterface

// File: rtl/hilo_unit.sv
// HI/LO register unit: models mult/div completion latency, MTHI/MTLO writes,
// MFHI/MFLO reads with last-cycle forwarding, and hazard stalls.
module hilo_unit #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input logic       clk,
  input logic       rst_n,
  hilo_unit_if.slave bus
);
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  logic [CW-1:0] cnt;
  logic [31:0]   pend_hi, pend_lo, hi_r, lo_r;
  logic          is_div, md_req, mt_req, mf_req, busy, last;

  // Priority md > mt > mf; masked requests behave as if absent.
  always_comb begin
    is_div = (bus.alusignal == 4'b1111);
    md_req = bus.ex_valid & ((bus.alusignal == 4'b1001) | is_div);
    mt_req = bus.ex_valid & (bus.mthi | bus.mtlo) & ~md_req;
    mf_req = bus.ex_valid & (bus.mfhi | bus.mflo) & ~md_req & ~mt_req;
    busy   = (cnt != '0);
    last   = (cnt == CW'(1));
  end

  always_comb begin
    bus.rdata = '0;
    if (mf_req) begin
      if (bus.mfhi) bus.rdata = last ? pend_hi : hi_r;
      else          bus.rdata = last ? pend_lo : lo_r;
    end
  end

  // In the final busy cycle a read is served from pend_*, so only earlier cycles stall.
  assign bus.stall = busy & (md_req | mt_req | (mf_req & ~last));
  assign bus.busy  = busy;
  assign bus.hi_q  = hi_r;
  assign bus.lo_q  = lo_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      hi_r    <= '0;
      lo_r    <= '0;
    end else if (!busy) begin
      if (md_req) begin
        pend_hi <= bus.alu_hi;
        pend_lo <= bus.alu_lo;
        cnt     <= is_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
      end else if (mt_req) begin
        if (bus.mthi) hi_r <= bus.wdata;
        if (bus.mtlo) lo_r <= bus.wdata;
      end
    end else begin
      cnt <= cnt - CW'(1);
      if (last) begin
        hi_r <= pend_hi;
        lo_r <= pend_lo;
      end
    end
  end
endmodule
